// File: rtl/fs_dither_sequencer.sv
// Floyd-Steinberg error-diffusion sequencer: walks an 8-bit image in SRAM
// in raster order, thresholds each pixel and spreads the error to E/SW/S/SE.
module fs_dither_sequencer #(
    parameter int IMAGEX           = 64,
    parameter int IMAGEY           = 64,
    parameter int RGB_SIZE         = 8,
    parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGEX*IMAGEY),
    parameter int THRESHOLD        = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [IMAGE_ADDR_WIDTH-1:0] mem_addr,
    output logic                        mem_rd_en,
    output logic                        mem_wr_en,
    output logic [RGB_SIZE-1:0]         mem_wdata,
    input  logic [RGB_SIZE-1:0]         mem_rdata,
    output logic [IMAGE_ADDR_WIDTH-1:0] cur_addr
);

    localparam int AW = IMAGE_ADDR_WIDTH;
    localparam int XW = (IMAGEX > 1) ? $clog2(IMAGEX) : 1;
    localparam int YW = (IMAGEY > 1) ? $clog2(IMAGEY) : 1;
    localparam int PW = RGB_SIZE + 6;

    localparam logic [RGB_SIZE:0]      THR  = (RGB_SIZE+1)'(THRESHOLD);
    localparam logic signed [PW-1:0]   PMAX = PW'((2**RGB_SIZE) - 1);
    localparam logic [XW-1:0]          XMAX = XW'(IMAGEX - 1);
    localparam logic [YW-1:0]          YMAX = YW'(IMAGEY - 1);
    localparam logic [AW-1:0]          OFF_E  = AW'(1);
    localparam logic [AW-1:0]          OFF_SW = AW'(IMAGEX - 1);
    localparam logic [AW-1:0]          OFF_S  = AW'(IMAGEX);
    localparam logic [AW-1:0]          OFF_SE = AW'(IMAGEX + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_C,
        WB_C,
        RD_N,
        WB_N,
        NEXT,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [XW-1:0]             x_q, x_d;
    logic [YW-1:0]             y_q, y_d;
    logic [AW-1:0]             cur_q, cur_d;
    logic [1:0]                nbr_q, nbr_d;
    logic signed [RGB_SIZE:0]  err_q, err_d;
    logic [RGB_SIZE-1:0]       wdata_q;

    logic                      rd_raw, wr_raw;
    logic [AW-1:0]             addr_raw;
    logic [RGB_SIZE-1:0]       wval;

    logic                      last_x, last_y, first_x;
    logic [3:0]                nbr_valid;
    logic [2:0]                from_idx;
    logic                      found;
    logic [1:0]                pick;
    logic [AW-1:0]             nbr_addr;

    logic [RGB_SIZE-1:0]       pix_new;
    logic signed [RGB_SIZE:0]  err_new;
    logic [3:0]                weight;
    logic signed [PW-1:0]      err_ext, w_ext, prod, shifted, rd_ext, sum;
    logic [RGB_SIZE-1:0]       clamped;

    state_t                    adv_state;
    logic [XW-1:0]             adv_x;
    logic [YW-1:0]             adv_y;

    assign last_x  = (x_q == XMAX);
    assign last_y  = (y_q == YMAX);
    assign first_x = (x_q == '0);

    // Bit order is the diffusion order: E, SW, S, SE.
    assign nbr_valid[0] = !last_x;
    assign nbr_valid[1] = !last_y && !first_x;
    assign nbr_valid[2] = !last_y;
    assign nbr_valid[3] = !last_y && !last_x;

    assign from_idx = (state_q == WB_N) ? ({1'b0, nbr_q} + 3'd1) : 3'd0;

    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (nbr_valid[k] && (3'(k) >= from_idx)) begin
                found = 1'b1;
                pick  = 2'(k);
            end
        end
    end

    always_comb begin
        nbr_addr = cur_q + OFF_E;
        weight   = 4'd7;
        case (nbr_q)
            2'd0: begin
                nbr_addr = cur_q + OFF_E;
                weight   = 4'd7;
            end
            2'd1: begin
                nbr_addr = cur_q + OFF_SW;
                weight   = 4'd3;
            end
            2'd2: begin
                nbr_addr = cur_q + OFF_S;
                weight   = 4'd5;
            end
            default: begin
                nbr_addr = cur_q + OFF_SE;
                weight   = 4'd1;
            end
        endcase
    end

    assign pix_new = ({1'b0, mem_rdata} >= THR) ? '1 : '0;
    assign err_new = {1'b0, mem_rdata} - {1'b0, pix_new};

    // Signed product, arithmetic shift floors toward -inf, then saturate.
    assign err_ext = {{(PW-RGB_SIZE-1){err_q[RGB_SIZE]}}, err_q};
    assign w_ext   = {{(PW-4){1'b0}}, weight};
    assign prod    = err_ext * w_ext;
    assign shifted = prod >>> 4;
    assign rd_ext  = {{(PW-RGB_SIZE){1'b0}}, mem_rdata};
    assign sum     = shifted + rd_ext;

    always_comb begin
        clamped = sum[RGB_SIZE-1:0];
        if (sum[PW-1]) begin
            clamped = '0;
        end else if (sum > PMAX) begin
            clamped = '1;
        end
    end

    always_comb begin
        adv_state = RD_C;
        adv_x     = x_q;
        adv_y     = y_q;
        if (!last_x) begin
            adv_x = x_q + XW'(1);
        end else if (!last_y) begin
            adv_x = '0;
            adv_y = y_q + YW'(1);
        end else begin
            adv_state = DONE;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cur_d    = cur_q;
        nbr_d    = nbr_q;
        err_d    = err_q;
        rd_raw   = 1'b0;
        wr_raw   = 1'b0;
        addr_raw = '0;
        wval     = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = '0;
                    y_d     = '0;
                    cur_d   = '0;
                    nbr_d   = '0;
                    state_d = RD_C;
                end
            end
            RD_C: begin
                addr_raw = cur_q;
                rd_raw   = 1'b1;
                state_d  = WB_C;
            end
            WB_C, WB_N: begin
                wr_raw = 1'b1;
                if (state_q == WB_C) begin
                    addr_raw = cur_q;
                    wval     = pix_new;
                    err_d    = err_new;
                end else begin
                    addr_raw = nbr_addr;
                    wval     = clamped;
                end
                if (found) begin
                    nbr_d   = pick;
                    state_d = RD_N;
                end else begin
                    state_d = adv_state;
                    x_d     = adv_x;
                    y_d     = adv_y;
                    if (adv_state == RD_C) begin
                        cur_d = cur_q + AW'(1);
                    end
                end
            end
            RD_N: begin
                addr_raw = nbr_addr;
                rd_raw   = 1'b1;
                state_d  = WB_N;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes are masked by rst so an abort issues no access at that edge.
    assign mem_rd_en = rd_raw && !rst;
    assign mem_wr_en = wr_raw && !rst;
    assign mem_addr  = addr_raw;
    assign mem_wdata = mem_wr_en ? wval : wdata_q;
    assign cur_addr  = cur_q;
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cur_q   <= '0;
            nbr_q   <= '0;
            err_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cur_q   <= cur_d;
            nbr_q   <= nbr_d;
            err_q   <= err_d;
            wdata_q <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_fs_dither_sequencer.sv
// Directed bench for fs_dither_sequencer: 2x2 and 4x4 instances, each
// with a 1-cycle-latency SRAM model and a write log.
module tb_fs_dither_sequencer;

    logic clk;
    logic rst2, rst4, start2, start4;
    logic busy2, done2, rd2, wr2, busy4, done4, rd4, wr4;
    logic [1:0] a2, cur2;
    logic [3:0] a4, cur4;
    logic [7:0] wd2, rdat2, wd4, rdat4;

    logic [7:0] mem2 [4];
    logic [7:0] mem4 [16];
    logic [7:0] img2 [4];
    logic       load2, load4;

    int log2_a[$], log2_d[$], log4_a[$], log4_d[$];
    int busy2_cyc, busy4_cyc, done4_cnt, clash;
    int ncomp, nfail;
    int e2a[10], e2d[10], e2f[4];
    int e4[$];

    fs_dither_sequencer #(.IMAGEX(2), .IMAGEY(2)) u2 (
        .clk(clk), .rst(rst2), .start(start2), .busy(busy2), .done(done2),
        .mem_addr(a2), .mem_rd_en(rd2), .mem_wr_en(wr2), .mem_wdata(wd2),
        .mem_rdata(rdat2), .cur_addr(cur2)
    );

    fs_dither_sequencer #(.IMAGEX(4), .IMAGEY(4)) u4 (
        .clk(clk), .rst(rst4), .start(start4), .busy(busy4), .done(done4),
        .mem_addr(a4), .mem_rd_en(rd4), .mem_wr_en(wr4), .mem_wdata(wd4),
        .mem_rdata(rdat4), .cur_addr(cur4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        busy2_cyc = 0;
        busy4_cyc = 0;
        done4_cnt = 0;
        clash     = 0;
    end

    always @(posedge clk) begin
        if (load2) mem2 <= img2;
        if (load4) for (int i = 0; i < 16; i++) mem4[i] <= 8'd0;
        if (rd2) rdat2 <= mem2[a2];
        if (rd4) rdat4 <= mem4[a4];
        if (wr2) begin
            mem2[a2] <= wd2;
            log2_a.push_back(int'(a2));
            log2_d.push_back(int'(wd2));
        end
        if (wr4) begin
            mem4[a4] <= wd4;
            log4_a.push_back(int'(a4));
            log4_d.push_back(int'(wd4));
        end
        if (busy2) busy2_cyc++;
        if (busy4) busy4_cyc++;
        if (done4) done4_cnt++;
        if ((rd2 && wr2) || (rd4 && wr4)) clash++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run2(input string tag);
        int base, b0, n;
        load2 = 1'b1;
        @(negedge clk);
        load2 = 1'b0;
        base = log2_a.size();
        b0 = busy2_cyc;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check({tag, "_busy_rise"}, busy2, 1);
        n = 0;
        while (!done2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, done2, 1);
        check({tag, "_busy_at_done"}, busy2, 0);
        check({tag, "_cycles"}, busy2_cyc - b0, 20);
        check({tag, "_nwrites"}, log2_a.size() - base, 10);
        for (int i = 0; i < 10; i++) begin
            if (base + i < log2_a.size()) begin
                check($sformatf("%s_wa%0d", tag, i), log2_a[base+i], e2a[i]);
                check($sformatf("%s_wd%0d", tag, i), log2_d[base+i], e2d[i]);
            end
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_mem%0d", tag, i), mem2[i], e2f[i]);
        @(negedge clk);
    endtask

    task automatic wait_done4(input string tag);
        int n;
        n = 0;
        while (!done4 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, done4, 1);
        check({tag, "_busy_at_done"}, busy4, 0);
    endtask

    initial begin
        int base, b0, d0, nz, n, sz;
        ncomp = 0;
        nfail = 0;
        rst2 = 1'b1;
        rst4 = 1'b1;
        start2 = 1'b0;
        start4 = 1'b0;
        load2 = 1'b0;
        load4 = 1'b0;
        for (int i = 0; i < 4; i++) img2[i] = 8'd0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) begin
                e4.push_back(y*4 + x);
                if (x < 3) e4.push_back(y*4 + x + 1);
                if (y < 3 && x > 0) e4.push_back(y*4 + x + 3);
                if (y < 3) e4.push_back(y*4 + x + 4);
                if (y < 3 && x < 3) e4.push_back(y*4 + x + 5);
            end

        repeat (2) @(negedge clk);
        start2 = 1'b1;
        start4 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy2", busy2, 0);
        check("rst_done2", done2, 0);
        check("rst_rd2", rd2, 0);
        check("rst_wr2", wr2, 0);
        check("rst_addr2", a2, 0);
        check("rst_wdata2", wd2, 0);
        check("rst_cur2", cur2, 0);
        check("rst_busy4", busy4, 0);
        check("rst_strobe4", {rd4, wr4, done4}, 0);
        check("rst_nlog", log2_a.size() + log4_a.size(), 0);
        start2 = 1'b0;
        start4 = 1'b0;
        @(negedge clk);
        rst2 = 1'b0;
        rst4 = 1'b0;
        @(negedge clk);
        check("idle_busy2", busy2, 0);

        img2 = '{8'd100, 8'd100, 8'd100, 8'd100};
        e2a = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3};
        e2d = '{0, 143, 131, 106, 255, 110, 71, 0, 119, 0};
        e2f = '{0, 255, 0, 0};
        run2("flat100");

        img2 = '{8'd127, 8'd250, 8'd0, 8'd0};
        e2a = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3};
        e2d = '{0, 255, 39, 7, 255, 39, 7, 0, 24, 0};
        e2f = '{0, 255, 0, 0};
        run2("satpos");

        img2 = '{8'd128, 8'd0, 8'd0, 8'd0};
        e2a = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3};
        e2d = '{255, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        e2f = '{255, 0, 0, 0};
        run2("satneg");

        load4 = 1'b1;
        @(negedge clk);
        load4 = 1'b0;
        base = log4_a.size();
        b0 = busy4_cyc;
        d0 = done4_cnt;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("z4_busy_rise", busy4, 1);
        repeat (30) @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4("z4");
        check("z4_cycles", busy4_cyc - b0, 116);
        check("z4_nwrites", log4_a.size() - base, e4.size());
        nz = 0;
        for (int i = 0; i < e4.size(); i++) begin
            if (base + i < log4_a.size()) begin
                check($sformatf("z4_wa%0d", i), log4_a[base+i], e4[i]);
                if (log4_d[base+i] != 0) nz++;
            end
        end
        check("z4_nonzero_writes", nz, 0);
        @(negedge clk);
        check("z4_done_gone", done4, 0);
        check("z4_done_count", done4_cnt - d0, 1);

        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("b2b_busy", busy4, 1);
        n = 0;
        while (!(rd4 && cur4 == 4'd5 && a4 != 4'd5) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("abort_find_rdn", {rd4, cur4}, {1'b1, 4'd5});
        @(negedge clk);
        check("abort_in_wbn", {wr4, a4}, {1'b1, 4'd6});
        sz = log4_a.size();
        rst4 = 1'b1;
        #1;
        check("abort_wr_masked", wr4, 0);
        @(negedge clk);
        check("abort_busy", busy4, 0);
        check("abort_done", done4, 0);
        check("abort_strobes", {rd4, wr4}, 0);
        check("abort_addr", a4, 0);
        check("abort_wdata", wd4, 0);
        check("abort_cur", cur4, 0);
        check("abort_no_write", log4_a.size(), sz);
        rst4 = 1'b0;
        @(negedge clk);

        base = log4_a.size();
        b0 = busy4_cyc;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4("rerun");
        check("rerun_cycles", busy4_cyc - b0, 116);
        check("rerun_nwrites", log4_a.size() - base, e4.size());
        @(negedge clk);

        check("no_strobe_clash", clash, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/fs_dither_sequencer.md
Name: fs_dither_sequencer

Overview:
- Controller that runs Floyd-Steinberg error diffusion in place over an 8-bit grayscale image held in the pixel SRAM.
- Walks pixels in raster order. For each pixel it reads the value, writes back the thresholded value, then read-modify-writes the valid E/SW/S/SE neighbours with weighted error.
- Sole master of one SRAM port during a run; sits between the load/readout logic and the SRAM.

Parameters:
- IMAGEX, 64, image width in pixels (>=2)
- IMAGEY, 64, image height in pixels (>=2)
- RGB_SIZE, 8, pixel width in bits
- IMAGE_ADDR_WIDTH, $clog2(IMAGEX*IMAGEY), SRAM address width
- THRESHOLD, 128, pixel >= THRESHOLD quantises to all-ones, else 0

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a run; sampled only in IDLE
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse after the final write
- mem_addr  out  IMAGE_ADDR_WIDTH  SRAM address (y*IMAGEX + x)
- mem_rd_en  out  1  SRAM read strobe
- mem_wr_en  out  1  SRAM write strobe
- mem_wdata  out  RGB_SIZE  SRAM write data
- mem_rdata  in  RGB_SIZE  SRAM read data, valid the cycle after mem_rd_en (1-cycle latency)
- cur_addr  out  IMAGE_ADDR_WIDTH  index of the pixel being processed (debug/progress)

Behaviour:
- Interface: one clock domain; reset is synchronous and active-high (clk, rst).
- Reset: state=IDLE; busy, done, mem_rd_en, mem_wr_en = 0; mem_addr, mem_wdata, cur_addr, x, y, err = 0. A reset mid-run aborts at the next edge with no further SRAM access. Image contents are left as-is.
- States: IDLE, RD_C, WB_C, RD_N, WB_N, NEXT, DONE.
- IDLE: when start=1, clear x/y/nbr, go to RD_C. busy rises the cycle RD_C is entered. Start is ignored in all other states.
- RD_C: mem_addr=cur, mem_rd_en=1.
- WB_C: old=mem_rdata.
  - new = (old >= THRESHOLD) ? all-ones : 0.
  - Write new to cur (mem_wr_en=1).
  - Latch err = old - new as a signed RGB_SIZE+1-bit value; range is -(2^RGB_SIZE-1-THRESHOLD)..THRESHOLD-1.
  - Select the first valid neighbour. If none is valid, go to NEXT.
- Neighbour order and validity (weights in brackets):
  - E (7): x < IMAGEX-1.
  - SW (3): y < IMAGEY-1 and x > 0.
  - S (5): y < IMAGEY-1.
  - SE (1): y < IMAGEY-1 and x < IMAGEX-1.
  - Invalid neighbours are skipped with zero cycles. No wrap into the adjacent row.
- RD_N: read the neighbour address.
- WB_N: write clamp(mem_rdata + ((err*w) >>> 4)) to the same address.
  - Product is signed and wide enough for 15*max|err|.
  - The shift is arithmetic (floor toward -inf).
  - The sum is clamped to 0..2^RGB_SIZE-1.
  - Then go to the next valid neighbour's RD_N, or to NEXT.
- NEXT: combinational into the following RD_C, with no extra cycle.
  - If x < IMAGEX-1: x++.
  - Else if y < IMAGEY-1: x=0, y++.
  - Else: go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Strobes: mem_rd_en and mem_wr_en are never both high; both are 0 in IDLE and DONE.
- Timing: each pixel costs 2 + 2*(valid neighbours) cycles. Interior pixels take 10 cycles; the last pixel takes 2.
- Data hazard: none. Every read-modify-write completes before the next read, so updates from pixel n are visible to pixel n+1.
- mem_wdata holds its last value when mem_wr_en=0.

Test Plan:
- Reset, then pulse start with rst held -> no SRAM strobes, busy=0, done=0.
- IMAGEX=IMAGEY=2, image {100,100,100,100}, start -> final SRAM {0,255,0,0}. Intermediate writes must be:
  - pixel 0: 0@0, 143@1, 131@2, 106@3
  - pixel 1: 255@1, 110@2 (SW), 71@3 (S)
  - pixel 2: 0@2, 119@3
  - pixel 3: 0@3
- 2x2 image {127,250,0,0} -> pixel 1 neighbour write is 255 (saturates from 305). Negative-clamp case: {128,0,0,0} gives err=-127 and writes 0@1 (0-56 clamps).
- 4x4 image of all 0 -> every write value is 0; busy high exactly 116 cycles; done pulses once on the cycle busy falls; SW never issued at x=0; E/SE never issued at x=3.
- Assert rst during WB_N of pixel 5 of a 4x4 run -> next cycle all outputs at reset values, no write to a neighbour of pixel 5; a new start completes normally.
- Pulse start while busy -> ignored; run length and done count unchanged. Back-to-back start the cycle after done -> second run begins.
